lisnoc_local_packetizer: RTL

LISNOC_LOCAL_PACKETIZER -- requirements
Module: lisnoc_local_packetizer

---
 rtl/lisnoc_local_packetizer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lisnoc_local_packetizer.sv
// lisnoc_local_packetizer
//   Turns a packet request (destination, virtual channel, payload length) plus
//   a stream of payload words into LISNoC flits for a router local input.
//   A header flit (or a single flit when len is zero) is emitted first, then
//   len payload flits, the final one typed LAST.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_*_i/o      packet request handshake: destination, VC, payload length
//   data_*_i/o     payload word stream (valid/ready)
//   out_flit_o     flit to router, type field in the MSBs
//   out_valid_o    per-VC valid (one-hot on the packet's VC)
//   out_ready_i    per-VC ready (only the packet's VC is observed)
//   busy_o         packet in progress
//   tx_count_o     number of completed packets (wrapping)
module lisnoc_local_packetizer #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ph_dest_width   = 5,
  parameter int vchannels       = 2,
  parameter int vc_width        = 1,
  parameter int len_width       = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       req_valid_i,
  output logic                                       req_ready_o,
  input  logic [ph_dest_width-1:0]                   req_dest_i,
  input  logic [vc_width-1:0]                        req_vc_i,
  input  logic [len_width-1:0]                       req_len_i,
  input  logic [flit_data_width-1:0]                 data_i,
  input  logic                                       data_valid_i,
  output logic                                       data_ready_o,
  output logic [flit_data_width+flit_type_width-1:0] out_flit_o,
  output logic [vchannels-1:0]                       out_valid_o,
  input  logic [vchannels-1:0]                       out_ready_i,
  output logic                                       busy_o,
  output logic [15:0]                                tx_count_o
);

  localparam logic [flit_type_width-1:0] TYPE_PAYLOAD = flit_type_width'(2'b00);
  localparam logic [flit_type_width-1:0] TYPE_HEADER  = flit_type_width'(2'b01);
  localparam logic [flit_type_width-1:0] TYPE_LAST    = flit_type_width'(2'b10);
  localparam logic [flit_type_width-1:0] TYPE_SINGLE  = flit_type_width'(2'b11);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEADER  = 2'b01,
    PAYLOAD = 2'b10
  } state_e;

  state_e                     state_q, state_d;
  logic [ph_dest_width-1:0]   dest_q, dest_d;
  logic [vc_width-1:0]        vc_q, vc_d;
  logic [len_width-1:0]       len_q, len_d;
  logic [len_width-1:0]       remaining_q, remaining_d;
  logic [15:0]                tx_count_q, tx_count_d;

  logic [vc_width-1:0]        vc_map_s;
  logic [vchannels-1:0]       vc_mask_s;
  logic                       ready_sel_s;
  logic [flit_data_width-1:0] hdr_data_s;

  // Out-of-range VC requests are folded onto VC 0.
  always_comb begin
    if ({1'b0, req_vc_i} < (vc_width+1)'(vchannels)) begin
      vc_map_s = req_vc_i;
    end else begin
      vc_map_s = '0;
    end
  end

  // One-hot mask of the latched VC; ready on any other VC is masked away.
  always_comb begin
    vc_mask_s = '0;
    for (int i = 0; i < vchannels; i++) begin
      vc_mask_s[i] = (vc_q == vc_width'(i));
    end
    ready_sel_s = |(out_ready_i & vc_mask_s);
  end

  // Header payload: destination in the top bits, length in the low bits.
  always_comb begin
    hdr_data_s = '0;
    hdr_data_s[flit_data_width-1 -: ph_dest_width] = dest_q;
    hdr_data_s[len_width-1:0] = len_q;
  end

  // Next-state and flit/handshake outputs.
  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    vc_d         = vc_q;
    len_d        = len_q;
    remaining_d  = remaining_q;
    tx_count_d   = tx_count_q;
    req_ready_o  = 1'b0;
    data_ready_o = 1'b0;
    out_valid_o  = '0;
    out_flit_o   = '0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          dest_d  = req_dest_i;
          vc_d    = vc_map_s;
          len_d   = req_len_i;
          state_d = HEADER;
        end else begin
          state_d = IDLE;
        end
      end
      HEADER: begin
        out_valid_o = vc_mask_s;
        out_flit_o  = {(len_q == '0) ? TYPE_SINGLE : TYPE_HEADER, hdr_data_s};
        if (ready_sel_s) begin
          if (len_q == '0) begin
            state_d    = IDLE;
            tx_count_d = tx_count_q + 16'd1;
          end else begin
            state_d     = PAYLOAD;
            remaining_d = len_q;
          end
        end else begin
          state_d = HEADER;
        end
      end
      PAYLOAD: begin
        // Payload passes straight through; the source holds data_i until ready.
        out_flit_o   = {(remaining_q == len_width'(1)) ? TYPE_LAST : TYPE_PAYLOAD, data_i};
        out_valid_o  = vc_mask_s & {vchannels{data_valid_i}};
        data_ready_o = ready_sel_s;
        if (data_valid_i && ready_sel_s) begin
          remaining_d = remaining_q - len_width'(1);
          if (remaining_q == len_width'(1)) begin
            state_d    = IDLE;
            tx_count_d = tx_count_q + 16'd1;
          end else begin
            state_d = PAYLOAD;
          end
        end else begin
          state_d = PAYLOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and packet context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      vc_q        <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      tx_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      vc_q        <= vc_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      tx_count_q  <= tx_count_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign tx_count_o = tx_count_q;

endmodule
